// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Produces one result bit per cycle: radix-2 shift-add multiply and restoring divide.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Handshake: start is sampled only while busy is low; busy then stays high
  // for WIDTH+1 cycles, and done pulses for one cycle with busy low and hi/lo valid.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Most-negative operand negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
  end

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;
  logic           div_ok;

  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    div_ok    = ~div_trial[WIDTH];
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod = {work_hi, work_lo};
    if (sgn_a ^ sgn_b) prod = -prod;
    quot = (sgn_a ^ sgn_b) ? -work_lo : work_lo;
    rem  = sgn_a ? -work_hi : work_hi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      sgn_a   <= 1'b0;
      sgn_b   <= 1'b0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            sgn_a   <= a_neg;
            sgn_b   <= b_neg;
            opnd    <= op[1] ? mag_b : mag_a;
            work_hi <= '0;
            work_lo <= op[1] ? mag_a : mag_b;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            work_hi <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], div_ok};
          end else begin
            work_hi <= mul_sum[WIDTH:1];
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          end
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= quot;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: directed corner cases plus random back-to-back operations
// checked against an arithmetic reference model.
module tb_mips_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int n_checks = 0;
  int n_fail = 0;
  int busy_cyc = 0;
  logic [63:0] exp_q[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint q;
    longint r;
    logic [63:0] p;
    case (o)
      2'd0: p = {32'd0, x} * {32'd0, y};
      2'd1: p = 64'(sx * sy);
      2'd2: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) p = {x, (sx < 0) ? 32'd1 : 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {32'(r), 32'(q)};
        end
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    if (busy) busy_cyc++;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    busy_cyc = 0;
    tick();
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    logic [63:0] e;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(busy_cyc), 64'd33);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    last_hi = e[63:32];
    last_lo = e[31:0];
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start_op(o, x, y);
    wait_done(tag);
    tick();
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7);
    do_op("mult_minmin", 2'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2);
    do_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu_zero", 2'd2, 32'd100, 32'd0);
    do_op("div_zero", 2'd3, 32'hFFFF_FFFB, 32'd0);

    // Requests while busy are dropped and hi/lo hold until the result lands.
    start_op(2'd2, 32'd100, 32'd7);
    repeat (5) tick();
    check("run_hold", {hi, lo}, {last_hi, last_lo});
    op = 2'd0; a = 32'd2; b = 32'd2; start = 1'b1; mthi = 1'b1; wdata = 32'h1234;
    tick();
    start = 1'b0; mthi = 1'b0;
    wait_done("busy_ignore");
    tick();
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h1234, 32'h1234});
    mtlo = 1'b1; wdata = 32'h5678;
    tick();
    mtlo = 1'b0;
    check("mtlo_only", {hi, lo}, {32'h1234, 32'h5678});
    check("move_no_done", 64'(done), 64'd0);

    // start beats a simultaneous move while idle
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    start_op(2'd0, 32'd6, 32'd9);
    mthi = 1'b0;
    wait_done("start_wins");

    // Back-to-back random stream, each start issued in the done cycle
    for (int i = 0; i < 40; i++) begin
      start_op(2'($urandom_range(0, 3)), pick(), pick());
      wait_done($sformatf("rand%0d", i));
    end
    tick();

    // Asynchronous reset mid-run aborts the operation
    start_op(2'd0, 32'd123, 32'd456);
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("arst_no_done", 64'(seen), 64'd0);
    do_op("after_rst", 2'd3, 32'hFFFF_FF9C, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
